// File: rtl/conv_udiv_seq_21ns_13ns_if.sv
// Operand/result handshake bundle for the sequential 21/13-bit unsigned divider.
interface conv_udiv_seq_21ns_13ns_if #(
  parameter int DIVIDEND_W = 21,
  parameter int DIVISOR_W  = 13
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] din0;
  logic [DIVISOR_W-1:0]  din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quot;
  logic [DIVISOR_W-1:0]  rem;
  logic                  div_by_zero;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero
  );
endinterface

// File: rtl/conv_udiv_seq_21ns_13ns.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, MSB first,
// with valid/ready on both sides and a one-cycle divide-by-zero shortcut.
module conv_udiv_seq_21ns_13ns #(
  parameter int DIVIDEND_W = 21,
  parameter int DIVISOR_W  = 13
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  conv_udiv_seq_21ns_13ns_if.slave   bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] qreg_q, qreg_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    shifted_s;
  logic [DIVISOR_W:0]    diff_s;
  logic                  fits_s;

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      qreg_q    <= {DIVIDEND_W{1'b0}};
      prem_q    <= {DIVISOR_W{1'b0}};
      divisor_q <= {DIVISOR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qreg_q    <= qreg_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      dbz_q     <= dbz_d;
    end
  end

  // Next-state and restoring-division step.
  always_comb begin
    state_d   = state_q;
    qreg_d    = qreg_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;

    // The restored remainder is always below the divisor, so the shifted
    // DIVISOR_W+1-bit partial remainder cannot overflow.
    shifted_s = {prem_q, qreg_q[DIVIDEND_W-1]};
    fits_s    = (shifted_s >= {1'b0, divisor_q});
    diff_s    = shifted_s - {1'b0, divisor_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          divisor_d = bus.din1;
          cnt_d     = {CNT_W{1'b0}};
          if (bus.din1 == {DIVISOR_W{1'b0}}) begin
            qreg_d  = {DIVIDEND_W{1'b1}};
            prem_d  = bus.din0[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            qreg_d  = bus.din0;
            prem_d  = {DIVISOR_W{1'b0}};
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (fits_s) begin
          prem_d = DIVISOR_W'(diff_s);
          qreg_d = {qreg_q[DIVIDEND_W-2:0], 1'b1};
        end else begin
          prem_d = DIVISOR_W'(shifted_s);
          qreg_d = {qreg_q[DIVIDEND_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quot        = qreg_q;
  assign bus.rem         = prem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/conv_udiv_seq_21ns_13ns.md
# conv_udiv_seq_21ns_13ns

Sequential unsigned radix-2 restoring divider for the conv core. It inverts the 8×13→21-bit product path, recovering a quotient and remainder from a 21-bit dividend and a 13-bit divisor, for example for normalising accumulated conv sums by a window or channel count. The block produces one quotient bit per cycle behind a valid/ready handshake on both input and output. It sits between the accumulator stage and the output quantiser.

## Interface
- DIVIDEND_W, 21, dividend and quotient width.
- DIVISOR_W, 13, divisor and remainder width.
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- din0  in  DIVIDEND_W  dividend, unsigned.
- din1  in  DIVISOR_W  divisor, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quot  out  DIVIDEND_W  quotient.
- rem  out  DIVISOR_W  remainder.
- div_by_zero  out  1  result came from a zero divisor; valid with out_valid.

## Operation
- FSM states and transitions:
  - IDLE → CALC on accept (in_valid && in_ready) when din1 != 0.
  - IDLE → DONE on accept when din1 == 0.
  - CALC → DONE when bit counter reaches DIVIDEND_W.
  - DONE → IDLE on out_valid && out_ready.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- On accept, the block latches the dividend into the quotient shift register and the divisor into a register. The partial remainder (DIVISOR_W+1 bits) and the bit counter are cleared.
- Each CALC cycle:
  - Shift {partial_rem, qreg} left by 1.
  - Trial subtract the divisor from the shifted partial remainder. If the result is non-negative, keep it and set qreg LSB to 1; otherwise restore and set LSB to 0.
  - Counter increments.
- Quotient bits are produced MSB first. Exactly DIVIDEND_W CALC cycles run per operation.
- DONE outputs:
  - quot = qreg.
  - rem = partial_rem[DIVISOR_W-1:0].
  - div_by_zero = 0 for a normal divide.
- Divide by zero: quot = all ones, rem = din0[DIVISOR_W-1:0], div_by_zero = 1.
- Results satisfy quot*din1 + rem == din0 and rem < din1 for every din1 != 0.
- quot, rem and div_by_zero hold stable throughout DONE, regardless of in_valid or operand changes.
- While not in IDLE, din0 and din1 are don't-care. Operands are sampled only on accept.

## Timing
- Reset values (asynchronous assert, synchronous-safe deassert):
  - State = IDLE, in_ready = 1 from the first edge after deassert.
  - out_valid = 0, quot = 0, rem = 0, div_by_zero = 0, counter = 0.
- Normal latency: accept at edge E0; out_valid rises after edge E0+DIVIDEND_W, i.e. 21 cycles.
- Divide-by-zero latency: out_valid rises after E0+1.
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises the following cycle.
- Throughput: one operation per DIVIDEND_W+2 cycles (23) with out_ready held high. There is no accept in the same cycle as the output handshake.
- Backpressure: DONE holds indefinitely while out_ready = 0, with no result change.
- Reset asserted mid-CALC or in DONE aborts the operation immediately. No out_valid is produced for the aborted operation.
- in_valid in a non-IDLE cycle is ignored and not queued. The upstream stage must hold the operands until in_ready.

## Test plan
- din0 = 1000000, din1 = 7 → after 21 cycles: quot = 142857, rem = 1, div_by_zero = 0.
- din0 = 2088705 (255·8191), din1 = 8191 → quot = 255, rem = 0. Repeat with din0 = 2097151, din1 = 1 → quot = 2097151, rem = 0.
- din0 = 5, din1 = 100 → quot = 0, rem = 5. din0 = 0, din1 = 3 → quot = 0, rem = 0.
- din0 = 12345, din1 = 0 → out_valid after 1 cycle: quot = 21'h1FFFFF, rem = 4153, div_by_zero = 1.
- Hold out_ready = 0 for 10 cycles in DONE while toggling in_valid with new operands → outputs stable, in_ready = 0, no second accept. Release out_ready → in_ready = 1 next cycle.
- Assert ap_rst_n = 0 at cycle 10 of CALC → out_valid = 0, in_ready = 1 after release. Then run a fresh 100/9 → quot = 11, rem = 1.
